// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, states, instruction classes.
package control_unit_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Address and branch-target sums reuse the ADD operation of the ALU.
    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        ST_RESET, ST_IDLE, ST_HALT,
        ST_F0, ST_F1, ST_F2,
        ST_T3, ST_T4, ST_T5, ST_T6, ST_T7
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU3, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;

endpackage

// File: rtl/control_unit_op_class.sv
// Maps the 5-bit opcode onto the instruction class the sequencer keys on.
module control_unit_op_class
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    // Pure lookup; unused opcodes 11100-11111 behave as nop.
    always_comb begin
        op_class = CL_NOP;
        case (opcode)
            OP_LD:   op_class = CL_LD;
            OP_LDI:  op_class = CL_LDI;
            OP_ST:   op_class = CL_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:    op_class = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:   op_class = CL_IMM;
            OP_MUL, OP_DIV:             op_class = CL_MULDIV;
            OP_NEG, OP_NOT:             op_class = CL_UNARY;
            OP_BR:   op_class = CL_BR;
            OP_JR:   op_class = CL_JR;
            OP_JAL:  op_class = CL_JAL;
            OP_IN:   op_class = CL_IN;
            OP_OUT:  op_class = CL_OUT;
            OP_MFHI: op_class = CL_MFHI;
            OP_MFLO: op_class = CL_MFLO;
            OP_HALT: op_class = CL_HALT;
            default: op_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Mini SRC control sequencer: state register, memory wait counter and per-state strobe decode.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int AUTO_RUN = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic [4:0]  alu_control,
    output logic        MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, InPortout,
    output logic        IRen, MARen, MDRen, Yen, Pen, IncPC, Zen, HIen, LOen, OutPorten,
    output logic        Read, Write,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, ConIn
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t    state, state_next;
    logic [2:0] wait_cnt, wait_next;
    op_class_t cls;
    logic [4:0] opcode;
    logic       mem_done;
    logic       ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];
    assign mem_done  = (wait_cnt == WAIT_LAST);

    control_unit_op_class u_op_class (
        .opcode   (opcode),
        .op_class (cls)
    );

    // State and wait counter; a low clr aborts whatever is in flight at this edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= ST_RESET;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Next-state sequencing and strobe decode from the registered state and opcode class.
    always_comb begin
        state_next = state;
        wait_next  = 3'd0;
        Run = 1'b0; alu_control = 5'd0;
        MDROut = 1'b0; HIout = 1'b0; LOout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0;
        Pout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
        IRen = 1'b0; MARen = 1'b0; MDRen = 1'b0; Yen = 1'b0; Pen = 1'b0; IncPC = 1'b0;
        Zen = 1'b0; HIen = 1'b0; LOen = 1'b0; OutPorten = 1'b0;
        Read = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; ConIn = 1'b0;
        case (state)
            ST_RESET: state_next = (AUTO_RUN != 0) ? ST_F0 : ST_IDLE;
            ST_IDLE:  if (!Stop) state_next = ST_F0;
            ST_HALT:  state_next = ST_HALT;
            ST_F0: begin
                if (Stop) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_F1;
                    Run = 1'b1; Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1;
                end
            end
            ST_F1: begin
                Run = 1'b1; Read = 1'b1; MDRen = 1'b1;
                if (mem_done) state_next = ST_F2;
                else          wait_next  = wait_cnt + 3'd1;
            end
            ST_F2: begin
                Run = 1'b1; MDROut = 1'b1; IRen = 1'b1;
                case (cls)
                    CL_NOP:  state_next = ST_F0;
                    CL_HALT: state_next = ST_HALT;
                    default: state_next = ST_T3;
                endcase
            end
            ST_T3: begin
                Run = 1'b1;
                state_next = ST_T4;
                case (cls)
                    CL_ALU3, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                    CL_LDI, CL_LD, CL_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Rout = 1'b1; Yen = 1'b1;
                    end
                    CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                    CL_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = opcode; end
                    CL_BR:     begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
                    CL_JR:     begin Gra = 1'b1; Rout = 1'b1; Pen = 1'b1; state_next = ST_F0; end
                    CL_JAL:    begin Pout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    CL_IN:     begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = ST_F0; end
                    CL_OUT:    begin Gra = 1'b1; Rout = 1'b1; OutPorten = 1'b1; state_next = ST_F0; end
                    CL_MFHI:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = ST_F0; end
                    CL_MFLO:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = ST_F0; end
                    default:   state_next = ST_F0;
                endcase
            end
            ST_T4: begin
                Run = 1'b1;
                state_next = ST_T5;
                case (cls)
                    CL_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = opcode; end
                    CL_IMM:    begin Cout = 1'b1; Zen = 1'b1; alu_control = opcode; end
                    CL_LDI, CL_LD, CL_ST: begin Cout = 1'b1; Zen = 1'b1; alu_control = ALU_ADD; end
                    CL_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = opcode; end
                    CL_UNARY:  begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = ST_F0; end
                    CL_BR:     begin Pout = 1'b1; Yen = 1'b1; end
                    CL_JAL:    begin Gra = 1'b1; Rout = 1'b1; Pen = 1'b1; state_next = ST_F0; end
                    default:   state_next = ST_F0;
                endcase
            end
            ST_T5: begin
                Run = 1'b1;
                state_next = ST_T6;
                case (cls)
                    CL_ALU3, CL_IMM, CL_LDI: begin
                        ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; state_next = ST_F0;
                    end
                    CL_LD, CL_ST: begin ZLOout = 1'b1; MARen = 1'b1; end
                    CL_MULDIV:    begin ZLOout = 1'b1; LOen = 1'b1; end
                    CL_BR:        begin Cout = 1'b1; Zen = 1'b1; alu_control = ALU_ADD; end
                    default:      state_next = ST_F0;
                endcase
            end
            ST_T6: begin
                Run = 1'b1;
                state_next = ST_F0;
                case (cls)
                    CL_LD: begin
                        Read = 1'b1; MDRen = 1'b1;
                        if (mem_done) state_next = ST_T7;
                        else begin
                            state_next = ST_T6;
                            wait_next  = wait_cnt + 3'd1;
                        end
                    end
                    CL_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; state_next = ST_T7; end
                    CL_MULDIV: begin ZHIout = 1'b1; HIen = 1'b1; end
                    CL_BR:     begin ZLOout = CON; Pen = CON; end
                    default:   state_next = ST_F0;
                endcase
            end
            ST_T7: begin
                Run = 1'b1;
                state_next = ST_F0;
                case (cls)
                    CL_LD: begin MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST: begin
                        Write = 1'b1;
                        if (!mem_done) begin
                            state_next = ST_T7;
                            wait_next  = wait_cnt + 3'd1;
                        end
                    end
                    default: state_next = ST_F0;
                endcase
            end
            default: state_next = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance with MEM_WAIT=0, one with MEM_WAIT=2.
module tb_control_unit;

    localparam logic [27:0] M_CONIN  = 28'd1 << 0;
    localparam logic [27:0] M_BAOUT  = 28'd1 << 1;
    localparam logic [27:0] M_ROUT   = 28'd1 << 2;
    localparam logic [27:0] M_RIN    = 28'd1 << 3;
    localparam logic [27:0] M_GRC    = 28'd1 << 4;
    localparam logic [27:0] M_GRB    = 28'd1 << 5;
    localparam logic [27:0] M_GRA    = 28'd1 << 6;
    localparam logic [27:0] M_WRITE  = 28'd1 << 7;
    localparam logic [27:0] M_READ   = 28'd1 << 8;
    localparam logic [27:0] M_OUTPEN = 28'd1 << 9;
    localparam logic [27:0] M_LOEN   = 28'd1 << 10;
    localparam logic [27:0] M_HIEN   = 28'd1 << 11;
    localparam logic [27:0] M_ZEN    = 28'd1 << 12;
    localparam logic [27:0] M_INCPC  = 28'd1 << 13;
    localparam logic [27:0] M_PEN    = 28'd1 << 14;
    localparam logic [27:0] M_YEN    = 28'd1 << 15;
    localparam logic [27:0] M_MDREN  = 28'd1 << 16;
    localparam logic [27:0] M_MAREN  = 28'd1 << 17;
    localparam logic [27:0] M_IREN   = 28'd1 << 18;
    localparam logic [27:0] M_INPO   = 28'd1 << 19;
    localparam logic [27:0] M_COUT   = 28'd1 << 20;
    localparam logic [27:0] M_POUT   = 28'd1 << 21;
    localparam logic [27:0] M_ZLOO   = 28'd1 << 22;
    localparam logic [27:0] M_ZHIO   = 28'd1 << 23;
    localparam logic [27:0] M_LOO    = 28'd1 << 24;
    localparam logic [27:0] M_HIO    = 28'd1 << 25;
    localparam logic [27:0] M_MDRO   = 28'd1 << 26;
    localparam logic [27:0] M_RUN    = 28'd1 << 27;

    localparam logic [27:0] E_F0 = M_RUN | M_POUT | M_MAREN | M_INCPC;
    localparam logic [27:0] E_F1 = M_RUN | M_READ | M_MDREN;
    localparam logic [27:0] E_F2 = M_RUN | M_MDRO | M_IREN;
    localparam logic [27:0] E_ADDR_T3 = M_RUN | M_GRB | M_BAOUT | M_ROUT | M_YEN;
    localparam logic [27:0] E_ADDR_T4 = M_RUN | M_COUT | M_ZEN;

    localparam logic [31:0] IR_ADD  = 32'h1891_8000;
    localparam logic [31:0] IR_LD   = 32'h0080_0055;
    localparam logic [31:0] IR_BR   = 32'h9880_0000;
    localparam logic [31:0] IR_MUL  = 32'h7888_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_ST   = 32'h1080_0010;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;

    logic        clk;
    logic        clr;
    logic [31:0] IR;
    logic        CON;
    logic        Stop;

    logic [1:0] Run, MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, InPortout;
    logic [1:0] IRen, MARen, MDRen, Yen, Pen, IncPC, Zen, HIen, LOen, OutPorten;
    logic [1:0] Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, ConIn;
    logic [4:0]  alu_control [2];
    logic [27:0] sig [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_unit #(.MEM_WAIT(g * 2), .AUTO_RUN(1)) dut (
            .clk(clk), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop),
            .Run(Run[g]), .alu_control(alu_control[g]),
            .MDROut(MDROut[g]), .HIout(HIout[g]), .LOout(LOout[g]), .ZHIout(ZHIout[g]),
            .ZLOout(ZLOout[g]), .Pout(Pout[g]), .Cout(Cout[g]), .InPortout(InPortout[g]),
            .IRen(IRen[g]), .MARen(MARen[g]), .MDRen(MDRen[g]), .Yen(Yen[g]), .Pen(Pen[g]),
            .IncPC(IncPC[g]), .Zen(Zen[g]), .HIen(HIen[g]), .LOen(LOen[g]),
            .OutPorten(OutPorten[g]), .Read(Read[g]), .Write(Write[g]),
            .Gra(Gra[g]), .Grb(Grb[g]), .Grc(Grc[g]), .Rin(Rin[g]), .Rout(Rout[g]),
            .BAout(BAout[g]), .ConIn(ConIn[g])
        );
        assign sig[g] = {Run[g], MDROut[g], HIout[g], LOout[g], ZHIout[g], ZLOout[g], Pout[g],
                         Cout[g], InPortout[g], IRen[g], MARen[g], MDRen[g], Yen[g], Pen[g],
                         IncPC[g], Zen[g], HIen[g], LOen[g], OutPorten[g], Read[g], Write[g],
                         Gra[g], Grb[g], Grc[g], Rin[g], Rout[g], BAout[g], ConIn[g]};
    end

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic c, input logic [31:0] ir, input logic cn,
                                 input logic st);
        clr  = c;
        IR   = ir;
        CON  = cn;
        Stop = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic [27:0] exp,
                               input logic [4:0] exp_alu);
        logic [32:0] obs;
        logic [32:0] want;
        obs  = {sig[idx], alu_control[idx]};
        want = {exp, exp_alu};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic pulseReset(input logic [31:0] ir);
        applyStimulus(1'b0, ir, 1'b0, 1'b0);
        tick();
        clr = 1'b1;
    endtask

    initial begin
        applyStimulus(1'b0, IR_ADD, 1'b0, 1'b0);

        // Reset held two cycles, then add R1,R2,R3.
        tick(); checkOutput("reset0", 0, 28'd0, 5'd0);
        tick(); checkOutput("reset1", 0, 28'd0, 5'd0);
        clr = 1'b1;
        tick(); checkOutput("add_f0", 0, E_F0, 5'd0);
        tick(); checkOutput("add_f1", 0, E_F1, 5'd0);
        tick(); checkOutput("add_f2", 0, E_F2, 5'd0);
        tick(); checkOutput("add_t3", 0, M_RUN | M_GRB | M_ROUT | M_YEN, 5'd0);
        tick(); checkOutput("add_t4", 0, M_RUN | M_GRC | M_ROUT | M_ZEN, 5'b00011);
        tick(); checkOutput("add_t5", 0, M_RUN | M_ZLOO | M_GRA | M_RIN, 5'd0);
        tick(); checkOutput("add_next_f0", 0, E_F0, 5'd0);

        // ld R1,0x55(R0) on the MEM_WAIT=2 instance.
        pulseReset(IR_LD);
        tick(); checkOutput("ld_f0", 1, E_F0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); checkOutput("ld_f1_wait", 1, E_F1, 5'd0);
        end
        tick(); checkOutput("ld_f2", 1, E_F2, 5'd0);
        tick(); checkOutput("ld_t3", 1, E_ADDR_T3, 5'd0);
        tick(); checkOutput("ld_t4", 1, E_ADDR_T4, 5'b00011);
        tick(); checkOutput("ld_t5", 1, M_RUN | M_ZLOO | M_MAREN, 5'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); checkOutput("ld_t6_wait", 1, M_RUN | M_READ | M_MDREN, 5'd0);
        end
        tick(); checkOutput("ld_t7", 1, M_RUN | M_MDRO | M_GRA | M_RIN, 5'd0);
        tick(); checkOutput("ld_next_f0", 1, E_F0, 5'd0);

        // brzr with CON=0, then again with CON=1.
        pulseReset(IR_BR);
        for (int pass = 0; pass < 2; pass++) begin
            CON = (pass == 1);
            tick(); checkOutput("br_f0", 0, E_F0, 5'd0);
            tick(); checkOutput("br_f1", 0, E_F1, 5'd0);
            tick(); checkOutput("br_f2", 0, E_F2, 5'd0);
            tick(); checkOutput("br_t3", 0, M_RUN | M_GRA | M_ROUT | M_CONIN, 5'd0);
            tick(); checkOutput("br_t4", 0, M_RUN | M_POUT | M_YEN, 5'd0);
            tick(); checkOutput("br_t5", 0, M_RUN | M_COUT | M_ZEN, 5'b00011);
            tick();
            if (pass == 0) checkOutput("br_t6_con0", 0, M_RUN, 5'd0);
            else           checkOutput("br_t6_con1", 0, M_RUN | M_ZLOO | M_PEN, 5'd0);
        end
        tick(); checkOutput("br_next_f0", 0, E_F0, 5'd0);

        // mul with Stop raised mid-instruction.
        pulseReset(IR_MUL);
        tick(); checkOutput("mul_f0", 0, E_F0, 5'd0);
        tick(); checkOutput("mul_f1", 0, E_F1, 5'd0);
        tick(); checkOutput("mul_f2", 0, E_F2, 5'd0);
        tick(); checkOutput("mul_t3", 0, M_RUN | M_GRA | M_ROUT | M_YEN, 5'd0);
        tick(); checkOutput("mul_t4", 0, M_RUN | M_GRB | M_ROUT | M_ZEN, 5'b01111);
        Stop = 1'b1;
        tick(); checkOutput("mul_t5", 0, M_RUN | M_ZLOO | M_LOEN, 5'd0);
        tick(); checkOutput("mul_t6", 0, M_RUN | M_ZHIO | M_HIEN, 5'd0);
        tick(); checkOutput("mul_stop_f0", 0, 28'd0, 5'd0);
        tick(); checkOutput("mul_idle", 0, 28'd0, 5'd0);
        tick(); checkOutput("mul_idle_hold", 0, 28'd0, 5'd0);
        Stop = 1'b0;
        tick(); checkOutput("idle_resume_f0", 0, E_F0, 5'd0);

        // nop takes only the three fetch cycles.
        pulseReset(IR_NOP);
        tick(); checkOutput("nop_f0", 0, E_F0, 5'd0);
        tick(); checkOutput("nop_f1", 0, E_F1, 5'd0);
        tick(); checkOutput("nop_f2", 0, E_F2, 5'd0);
        tick(); checkOutput("nop_next_f0", 0, E_F0, 5'd0);

        // halt parks the sequencer with every strobe low.
        pulseReset(IR_HALT);
        tick(); checkOutput("halt_f0", 0, E_F0, 5'd0);
        tick(); checkOutput("halt_f1", 0, E_F1, 5'd0);
        tick(); checkOutput("halt_f2", 0, E_F2, 5'd0);
        for (int k = 0; k < 20; k++) begin
            tick(); checkOutput("halt_hold", 0, 28'd0, 5'd0);
        end

        // st aborted by clr while Write is active.
        pulseReset(IR_ST);
        tick(); checkOutput("st_f0", 0, E_F0, 5'd0);
        tick(); checkOutput("st_f1", 0, E_F1, 5'd0);
        tick(); checkOutput("st_f2", 0, E_F2, 5'd0);
        tick(); checkOutput("st_t3", 0, E_ADDR_T3, 5'd0);
        tick(); checkOutput("st_t4", 0, E_ADDR_T4, 5'b00011);
        tick(); checkOutput("st_t5", 0, M_RUN | M_ZLOO | M_MAREN, 5'd0);
        tick(); checkOutput("st_t6", 0, M_RUN | M_GRA | M_ROUT | M_MDREN, 5'd0);
        tick(); checkOutput("st_t7", 0, M_RUN | M_WRITE, 5'd0);
        clr = 1'b0;
        tick(); checkOutput("st_abort", 0, 28'd0, 5'd0);
        tick(); checkOutput("st_abort_hold", 0, 28'd0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
